// File: rtl/spi_tx_if.sv
// spi_tx_if: host command/status handshake plus the SPI pins of one spi_tx initiator.
// The master side is the host/responder environment; spi_tx connects to the slave modport.
interface spi_tx_if;
    logic        wrt;
    logic [15:0] cmd;
    logic        len8_16;
    logic        edg;
    logic        MISO;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic [15:0] resp;
    logic        busy;
    logic        done;

    modport master (
        output wrt, cmd, len8_16, edg, MISO,
        input  SS_n, SCLK, MOSI, resp, busy, done
    );

    modport slave (
        input  wrt, cmd, len8_16, edg, MISO,
        output SS_n, SCLK, MOSI, resp, busy, done
    );
endinterface

// File: rtl/spi_tx.sv
// spi_tx: SPI initiator sending one 8- or 16-bit frame per wrt; all pin outputs are registered.
// Define SPI_TX_MISO_EN to build the MISO synchronizer and resp capture; otherwise resp is 0.
module spi_tx #(
    parameter int unsigned SCLK_DIV = 32
) (
    input logic     clk,
    input logic     rst_n,
    spi_tx_if.slave bus
);
    localparam int unsigned   H        = SCLK_DIV / 2;
    localparam int unsigned   CW       = $clog2(SCLK_DIV);
    localparam logic [CW-1:0] HALF_END = CW'(H - 1);
    localparam logic [CW-1:0] PER_END  = CW'(SCLK_DIV - 1);
    // MISO is read three clks after the sample edge to cover the synchronizer delay.
    localparam logic [CW-1:0] RX_TAP   = CW'(H + 2);

    typedef enum logic [2:0] {StIdle, StSetup, StXfer, StHold, StGap} state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [4:0]    edge_cnt_q;
    logic [15:0]   shreg_q;
    logic          edg_q;
    logic          len8_q;
    logic          ss_n_q;
    logic          sclk_q;
    logic          busy_q;
    logic          done_q;
    logic [4:0]    n_bits;
    logic          start;
    logic          frame_end;

    assign n_bits    = len8_q ? 5'd8 : 5'd16;
    assign start     = (state_q == StIdle) && bus.wrt;
    assign frame_end = (state_q == StHold) && (cnt_q == HALF_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            edge_cnt_q <= '0;
            shreg_q    <= '0;
            edg_q      <= 1'b1;
            len8_q     <= 1'b0;
            ss_n_q     <= 1'b1;
            sclk_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    sclk_q <= bus.edg;
                    if (bus.wrt) begin
                        state_q    <= StSetup;
                        cnt_q      <= '0;
                        edge_cnt_q <= '0;
                        edg_q      <= bus.edg;
                        len8_q     <= bus.len8_16;
                        shreg_q    <= bus.len8_16 ? {bus.cmd[7:0], 8'h00} : bus.cmd;
                        ss_n_q     <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                StSetup: begin
                    if (cnt_q == HALF_END) begin
                        state_q <= StXfer;
                        cnt_q   <= '0;
                        sclk_q  <= ~edg_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StXfer: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == HALF_END) begin
                        sclk_q     <= edg_q;
                        edge_cnt_q <= edge_cnt_q + 5'd1;
                    end else if (cnt_q == PER_END) begin
                        cnt_q <= '0;
                        if (edge_cnt_q == n_bits) begin
                            state_q <= StHold;
                        end else begin
                            sclk_q  <= ~edg_q;
                            shreg_q <= {shreg_q[14:0], 1'b0};
                        end
                    end
                end
                StHold: begin
                    if (cnt_q == HALF_END) begin
                        state_q <= StGap;
                        cnt_q   <= '0;
                        ss_n_q  <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StGap: begin
                    if (cnt_q == HALF_END) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.SS_n = ss_n_q;
    assign bus.SCLK = sclk_q;
    assign bus.MOSI = shreg_q[15];
    assign bus.busy = busy_q;
    assign bus.done = done_q;

`ifdef SPI_TX_MISO_EN
    logic        miso_s1_q;
    logic        miso_s2_q;
    logic [15:0] rshift_q;
    logic [15:0] resp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
            rshift_q  <= '0;
            resp_q    <= '0;
        end else begin
            miso_s1_q <= bus.MISO;
            miso_s2_q <= miso_s1_q;
            if (start) begin
                rshift_q <= '0;
            end else if ((state_q == StXfer) && (cnt_q == RX_TAP)) begin
                rshift_q <= {rshift_q[14:0], miso_s2_q};
            end
            if (frame_end) begin
                resp_q <= len8_q ? {8'h00, rshift_q[7:0]} : rshift_q;
            end
        end
    end

    assign bus.resp = resp_q;
`else
    logic unused_miso;
    logic unused_start;
    logic unused_frame_end;
    logic [CW-1:0] unused_rx_tap;
    assign unused_miso      = bus.MISO;
    assign unused_start     = start;
    assign unused_frame_end = frame_end;
    assign unused_rx_tap    = RX_TAP;
    assign bus.resp         = 16'h0000;
`endif
endmodule
